// File: rtl/prach_pkg.sv
// Shared PRACH TDM datapath types and half-band interpolator coefficients.
package prach_pkg;

   localparam int NumChannel = 16;

   typedef logic signed [15:0] sample_t;
   typedef logic signed [17:0] coef_t;

   localparam coef_t HbiCoef [2] = '{-18'd4134, 18'd36901};

   typedef struct packed {
      logic       sync;
      logic       dv;
      logic [7:0] chn;
   } ctl_t;

endpackage

// File: rtl/prach_hbi_ch_dly.sv
// Generic resettable delay line: o_q is i_d delayed by DELAY clocks.
module prach_hbi_ch_dly #(
   parameter int WIDTH = 10,
   parameter int DELAY = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DELAY-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[DELAY-1];

endmodule

// File: rtl/prach_hbi_ch.sv
// Channelised 2x half-band interpolator: per-slot centre (dp1) and interpolated (dp2) phases.
// Define PRACH_HBI_SAT_FLAG_EN to build the sticky dp2 saturation flag on sat_err.
module prach_hbi_ch
   import prach_pkg::*;
#(
   parameter int NUM_CHANNEL = 16,
   parameter int DW          = 16,
   parameter int CW          = 18,
   parameter int LATENCY     = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [DW-1:0] din_dq,
   input  logic                 din_dv,
   input  logic [7:0]           din_chn,
   input  logic                 sync_in,
   output logic signed [DW-1:0] dout_dp1,
   output logic signed [DW-1:0] dout_dp2,
   output logic                 dout_dv,
   output logic [7:0]           dout_chn,
   output logic                 sync_out,
   output logic                 sat_err
);

   localparam int Taps = 3*NUM_CHANNEL + 1;
   localparam int PW   = DW + 1;
   localparam int MW   = DW + CW + 1;
   localparam int SW   = MW + 1;
   localparam int RW   = SW - DW;
   localparam logic [5:0] FillMax = 6'(3*NUM_CHANNEL);
   localparam logic signed [CW-1:0] C0 = CW'(HbiCoef[0]);
   localparam logic signed [CW-1:0] C1 = CW'(HbiCoef[1]);

   logic signed [DW-1:0] r_x [Taps];
   logic signed [PW-1:0] r_pa0, r_pa1;
   logic signed [MW-1:0] r_m0, r_m1;
   logic signed [SW-1:0] r_sum;
   logic signed [DW-1:0] r_d1 [4];
   logic signed [DW-1:0] r_dp2_rs;
   logic [5:0]           r_fill;

   logic [SW-1:0]        w_rsum;
   logic [RW-1:0]        w_rnd;
   logic [RW-DW:0]       w_top;
   logic                 w_sat;
   logic signed [DW-1:0] w_dp2;
   ctl_t                 w_ctl_in, w_ctl;

   // Round half-up, then clamp: the rounded value fits DW bits only if its top bits agree.
   always_comb begin
      w_rsum = r_sum + (SW'(1) << (DW-1));
      w_rnd  = w_rsum[SW-1:DW];
      w_top  = w_rnd[RW-1:DW-1];
      w_sat  = !((&w_top) || !(|w_top));
      w_dp2  = w_rnd[DW-1:0];
      if (w_sat) w_dp2 = w_rnd[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   end

   // Tap line and arithmetic stages shift every clock and carry no reset.
   always_ff @(posedge clk) begin
      r_x[0] <= din_dq;
      for (int i = 1; i < Taps; i++) r_x[i] <= r_x[i-1];
      r_pa0 <= {r_x[0][DW-1], r_x[0]} + {r_x[Taps-1][DW-1], r_x[Taps-1]};
      r_pa1 <= {r_x[NUM_CHANNEL][DW-1], r_x[NUM_CHANNEL]}
             + {r_x[2*NUM_CHANNEL][DW-1], r_x[2*NUM_CHANNEL]};
      r_m0  <= $signed({{CW{r_pa0[PW-1]}}, r_pa0}) * $signed({{(MW-CW){C0[CW-1]}}, C0});
      r_m1  <= $signed({{CW{r_pa1[PW-1]}}, r_pa1}) * $signed({{(MW-CW){C1[CW-1]}}, C1});
      r_sum <= {r_m0[MW-1], r_m0} + {r_m1[MW-1], r_m1};
      r_dp2_rs <= w_dp2;
      r_d1[0]  <= r_x[2*NUM_CHANNEL];
      for (int i = 1; i < 4; i++) r_d1[i] <= r_d1[i-1];
   end

`ifdef PRACH_HBI_SAT_FLAG_EN
   logic r_sat_rs, r_sat_out, r_sat_err;

   always_ff @(posedge clk) r_sat_rs <= w_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_out <= 1'b0;
         r_sat_err <= 1'b0;
      end else begin
         r_sat_out <= r_sat_rs;
         r_sat_err <= (dout_dv & r_sat_out) | (r_sat_err & ~sync_out);
      end
   end

   assign sat_err = r_sat_err;
`else
   assign sat_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_dp1 <= '0;
         dout_dp2 <= '0;
         r_fill   <= '0;
      end else begin
         dout_dp1 <= r_d1[3];
         dout_dp2 <= r_dp2_rs;
         if (din_dv && r_fill != FillMax) r_fill <= r_fill + 6'd1;
      end
   end

   assign w_ctl_in = '{sync: sync_in, dv: din_dv, chn: din_chn};

   prach_hbi_ch_dly #(
      .WIDTH ($bits(ctl_t)),
      .DELAY (LATENCY)
   ) u_ctl_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_ctl_in),
      .o_q   (w_ctl)
   );

   // Until every tap holds a post-reset sample the dp2 value is meaningless.
   assign dout_dv  = w_ctl.dv & (r_fill == FillMax);
   assign dout_chn = w_ctl.chn;
   assign sync_out = w_ctl.sync;

endmodule

// File: tb/tb_prach_hbi_ch.sv
// Randomised scoreboard bench for prach_hbi_ch against a slot-history reference model.
module tb_prach_hbi_ch;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] din_dq = '0;
   logic               din_dv = 1'b0;
   logic [7:0]         din_chn = '0;
   logic               sync_in = 1'b0;
   logic signed [15:0] dout_dp1, dout_dp2;
   logic               dout_dv;
   logic [7:0]         dout_chn;
   logic               sync_out, sat_err;

   always #5 clk = ~clk;

   prach_hbi_ch dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_dq   (din_dq),
      .din_dv   (din_dv),
      .din_chn  (din_chn),
      .sync_in  (sync_in),
      .dout_dp1 (dout_dp1),
      .dout_dp2 (dout_dp2),
      .dout_dv  (dout_dv),
      .dout_chn (dout_chn),
      .sync_out (sync_out),
      .sat_err  (sat_err)
   );

   typedef struct {
      int dp1;
      int dp2;
      bit dv;
      int chn;
      bit sy;
      bit sat;
   } exp_t;

   exp_t q[$];
   int   h_dq [4096];
   bit   h_dv [4096];
   bit   h_sy [4096];
   int   g = 0;
   int   seg_base = 0;
   int   cnt = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_pops = 0;
   bit   exp_sat = 1'b0;
   int   sat_k = 0;

   task automatic chk(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int hist(input int i);
      return (i < 0) ? 0 : h_dq[i];
   endfunction

   // Ideal model: output k is input slot k filtered over its own channel's history.
   function automatic exp_t model(input int k, input int fill);
      exp_t   e;
      longint acc, fl;
      acc = longint'(hist(k) + hist(k-48)) * -4134
          + longint'(hist(k-16) + hist(k-32)) * 36901 + 32768;
      fl = (acc >= 0) ? acc / 65536 : -((-acc + 65535) / 65536);
      e.sat = (fl > 32767) || (fl < -32768);
      e.dp2 = (fl > 32767) ? 32767 : (fl < -32768) ? -32768 : int'(fl);
      e.dp1 = hist(k-32);
      e.dv  = h_dv[k] && (fill >= 48);
      e.chn = k % 16;
      e.sy  = h_sy[k];
      return e;
   endfunction

   // One TDM slot; the expectation for the slot six back is queued now because its
   // dv gate depends on how many valid inputs arrive up to its own output clock.
   task automatic step(input int dq, input bit dv, input bit sy);
      if (rst_n && (g - 6) >= seg_base) q.push_back(model(g - 6, cnt));
      din_dq  = 16'(dq);
      din_dv  = dv;
      din_chn = 8'(g % 16);
      sync_in = sy;
      h_dq[g] = dq;
      h_dv[g] = dv;
      h_sy[g] = sy;
      if (rst_n && dv) cnt++;
      g++;
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd_q();
      return int'($urandom_range(0, 16383)) - 8192;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         exp_sat = 1'b0;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         n_pops++;
         chk("dout_chn", dout_chn, e.chn);
         chk("sync_out", sync_out, e.sy);
         chk("dout_dv", dout_dv, e.dv);
         if (e.dv) begin
            chk("dout_dp1", dout_dp1, e.dp1);
            chk("dout_dp2", dout_dp2, e.dp2);
         end
         chk("sat_err", sat_err, exp_sat);
`ifdef PRACH_HBI_SAT_FLAG_EN
         exp_sat = (e.dv && e.sat) || (exp_sat && !e.sy);
`endif
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dp1"}, dout_dp1, 0);
      chk({tag, "_dp2"}, dout_dp2, 0);
      chk({tag, "_dv"}, dout_dv, 0);
      chk({tag, "_chn"}, dout_chn, 0);
      chk({tag, "_sync"}, sync_out, 0);
      chk({tag, "_sat"}, sat_err, 0);
   endtask

   initial begin
      #1;
      check_reset_outputs("rst0");
      for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0);
      rst_n = 1'b1;
      seg_base = g;
      cnt = 0;

      // warm-up and random traffic with dv gaps
      for (int i = 0; i < 200; i++) step(rnd_q(), $urandom_range(0, 9) != 0, (g % 64) == 0);

      // impulse on one ch3 slot
      for (int i = 0; i < 176; i++)
         step((i >= 64 && i < 80 && (g % 16) == 3) ? 16384 : 0, 1'b1, (g % 64) == 0);

      // full-scale DC
      for (int i = 0; i < 96; i++) step(32767, 1'b1, (g % 64) == 0);

      // ch5 pattern that drives dp2 past full scale
      for (int i = 0; i < 128; i++) begin
         if ((g % 16) == 5 && sat_k < 4) begin
            step((sat_k == 0 || sat_k == 3) ? -32768 : 32767, 1'b1, (g % 64) == 0);
            sat_k++;
         end else begin
            step(rnd_q(), 1'b1, (g % 64) == 0);
         end
      end

      // mid-stream asynchronous reset
      for (int i = 0; i < 30; i++) step(rnd_q(), 1'b1, (g % 64) == 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      q.delete();
      for (int i = 0; i < 3; i++) step(rnd_q(), 1'b1, 1'b0);
      rst_n = 1'b1;
      seg_base = g;
      cnt = 0;

      // re-warm-up with ch7 gaps plus random gaps
      for (int i = 0; i < 160; i++)
         step(rnd_q(), !((g % 16) == 7 && (i / 16) % 2 == 1) && ($urandom_range(0, 7) != 0),
              (g % 64) == 0);

      for (int i = 0; i < 300; i++)
         step(rnd_q(), ((g % 16) != 7 || (i % 48) >= 16) && ($urandom_range(0, 9) != 0),
              (g % 64) == 0);

      for (int i = 0; i < 8; i++) step(0, 1'b1, (g % 64) == 0);

      chk("queue_drained", q.size(), 0);
      chk("pops_seen", n_pops >= 1000, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
